// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core front end: fetch FSM states, next-PC
// select encoding and the default memory map used by the fetch controller.
package mips_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam int          IM_DEPTH_DEFAULT = 4096;

    typedef enum logic {
        FS_RUN  = 1'b0,
        FS_HALT = 1'b1
    } fetch_state_t;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_sel_t;

    // Word offset of a conditional branch, sign-extended to a byte offset.
    function automatic logic [31:0] br_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

    // j/jal target: stays inside the 256 MB region of the current PC.
    function automatic logic [31:0] jump_target(input logic [31:0] pc_cur,
                                                input logic [25:0] index);
        return {pc_cur[31:28], index, 2'b00};
    endfunction

endpackage

// File: rtl/npc_calc.sv
// Next-PC selection and legality check. Purely combinational: chooses among
// sequential, branch, jump and jump-register targets and range-checks the result.
module npc_calc
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          IM_DEPTH = IM_DEPTH_DEFAULT
) (
    input  logic [31:0] pc,
    input  logic        br_taken,
    input  logic [15:0] imm16,
    input  logic        jump,
    input  logic [25:0] instr_index,
    input  logic        jr,
    input  logic [31:0] rs_val,
    output npc_sel_t    sel,
    output logic [31:0] npc,
    output logic        legal
);

    // One past the last IM byte; 33 bits so a window ending at 2^32 still compares correctly.
    localparam logic [32:0] PC_LIMIT = {1'b0, PC_RESET} + 33'(4 * IM_DEPTH);

    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic        aligned;
    logic        above_base;
    logic        below_limit;

    assign pc_plus4  = pc + 32'd4;
    assign br_target = pc_plus4 + br_offset(imm16);
    assign j_target  = jump_target(pc, instr_index);

    always_comb begin
        sel = NPC_SEQ;
        if (jr) begin
            sel = NPC_JR;
        end else if (jump) begin
            sel = NPC_J;
        end else if (br_taken) begin
            sel = NPC_BR;
        end
    end

    always_comb begin
        npc = pc_plus4;
        case (sel)
            NPC_SEQ: npc = pc_plus4;
            NPC_BR:  npc = br_target;
            NPC_J:   npc = j_target;
            NPC_JR:  npc = rs_val;
            default: npc = pc_plus4;
        endcase
    end

    assign aligned     = (npc[1:0] == 2'b00);
    assign above_base  = ({1'b0, npc} >= {1'b0, PC_RESET});
    assign below_limit = ({1'b0, npc} < PC_LIMIT);
    assign legal       = aligned && above_base && below_limit;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: PC register, RUN/HALT FSM, retired-fetch
// counter and sticky illegal-target flag; drives the IM word address.
module fetch_ctrl
    import mips_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          IM_DEPTH = IM_DEPTH_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall,
    input  logic                        br_taken,
    input  logic [15:0]                 imm16,
    input  logic                        jump,
    input  logic [25:0]                 instr_index,
    input  logic                        jr,
    input  logic [31:0]                 rs_val,
    input  logic                        halt_req,
    output logic [31:0]                 pc,
    output logic [$clog2(IM_DEPTH)-1:0] im_addr,
    output logic                        fetch_valid,
    output logic                        halted,
    output logic                        pc_err,
    output logic [31:0]                 retired
);

    localparam int AW = $clog2(IM_DEPTH);

    // Handshake: fetch_valid marks the word at im_addr as consumed at the next
    // rising edge; stall=1 holds pc so the same word is presented again.

    fetch_state_t state;
    fetch_state_t state_next;
    npc_sel_t     npc_sel;
    logic [31:0]  npc;
    logic         npc_legal;
    logic         commit;
    logic [31:0]  pc_offset;

    npc_calc #(
        .PC_RESET (PC_RESET),
        .IM_DEPTH (IM_DEPTH)
    ) u_npc_calc (
        .pc          (pc),
        .br_taken    (br_taken),
        .imm16       (imm16),
        .jump        (jump),
        .instr_index (instr_index),
        .jr          (jr),
        .rs_val      (rs_val),
        .sel         (npc_sel),
        .npc         (npc),
        .legal       (npc_legal)
    );

    // The instruction at pc commits whenever the controller runs unstalled.
    assign commit = (state == FS_RUN) && !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FS_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FS_RUN: begin
                if (!stall && (halt_req || !npc_legal)) begin
                    state_next = FS_HALT;
                end
            end
            FS_HALT: state_next = FS_HALT;
            default: state_next = FS_RUN;
        endcase
    end

    always_comb begin
        fetch_valid = 1'b0;
        halted      = 1'b0;
        case (state)
            FS_RUN:  fetch_valid = !stall;
            FS_HALT: halted      = 1'b1;
            default: begin
                fetch_valid = 1'b0;
                halted      = 1'b0;
            end
        endcase
    end

    // halt_req wins over any redirect; an illegal target keeps pc on the
    // offending instruction so software can inspect it after the halt.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= PC_RESET;
            retired <= 32'd0;
            pc_err  <= 1'b0;
        end else if (commit) begin
            retired <= retired + 32'd1;
            if (!halt_req) begin
                if (npc_legal) begin
                    pc <= npc;
                end else begin
                    pc_err <= 1'b1;
                end
            end
        end
    end

    assign pc_offset = pc - PC_RESET;
    assign im_addr   = AW'(pc_offset >> 2);

    // Debug-only view of the redirect source, kept observable for checkers.
    npc_sel_t npc_sel_dbg;
    assign npc_sel_dbg = npc_sel;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, hand-written corner sequences
// and randomized traffic, all checked against a behavioural PC model.
module tb_fetch_ctrl;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;
    localparam int          IM_DEPTH = 4096;
    localparam int          AW       = 12;

    typedef struct {
        bit          rst;
        bit          stall;
        bit          br;
        logic [15:0] imm;
        bit          jump;
        logic [25:0] idx;
        bit          jr;
        logic [31:0] rs;
        bit          halt;
    } in_t;

    typedef struct {
        in_t         in;
        logic [31:0] exp_pc;
        logic [31:0] exp_ret;
        bit          exp_err;
        bit          exp_halted;
        bit          exp_valid;
    } vec_t;

    logic          clk;
    logic          reset;
    logic          stall;
    logic          br_taken;
    logic [15:0]   imm16;
    logic          jump;
    logic [25:0]   instr_index;
    logic          jr;
    logic [31:0]   rs_val;
    logic          halt_req;
    logic [31:0]   pc;
    logic [AW-1:0] im_addr;
    logic          fetch_valid;
    logic          halted;
    logic          pc_err;
    logic [31:0]   retired;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_pc;
    logic [31:0] m_ret;
    bit          m_err;
    bit          m_halt;

    vec_t tbl[$];

    fetch_ctrl #(
        .PC_RESET (PC_RESET),
        .IM_DEPTH (IM_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .br_taken    (br_taken),
        .imm16       (imm16),
        .jump        (jump),
        .instr_index (instr_index),
        .jr          (jr),
        .rs_val      (rs_val),
        .halt_req    (halt_req),
        .pc          (pc),
        .im_addr     (im_addr),
        .fetch_valid (fetch_valid),
        .halted      (halted),
        .pc_err      (pc_err),
        .retired     (retired)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    function automatic in_t mk(bit rst, bit stl, bit br, logic [15:0] imm, bit jmp,
                               logic [25:0] idx, bit jrr, logic [31:0] rs, bit hlt);
        in_t v;
        v.rst = rst; v.stall = stl; v.br = br; v.imm = imm; v.jump = jmp;
        v.idx = idx; v.jr = jrr; v.rs = rs; v.halt = hlt;
        return v;
    endfunction

    function automatic in_t idle();
        return mk(0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one committed instruction per unstalled RUN cycle.
    task automatic model_step(input in_t v);
        logic [31:0] tgt;
        longint      t64;
        int          off;
        if (v.rst) begin
            m_pc = PC_RESET; m_ret = 0; m_err = 0; m_halt = 0;
        end else if (!m_halt && !v.stall) begin
            m_ret = m_ret + 1;
            if (v.halt) begin
                m_halt = 1;
            end else begin
                off = int'($signed(v.imm));
                if (v.jr)        tgt = v.rs;
                else if (v.jump) tgt = {m_pc[31:28], v.idx, 2'b00};
                else if (v.br)   tgt = m_pc + 32'd4 + 32'(off * 4);
                else             tgt = m_pc + 32'd4;
                t64 = longint'(tgt);
                if (tgt[1:0] == 2'b00 && t64 >= longint'(PC_RESET)
                    && t64 < longint'(PC_RESET) + 4 * IM_DEPTH) begin
                    m_pc = tgt;
                end else begin
                    m_err  = 1;
                    m_halt = 1;
                end
            end
        end
    endtask

    task automatic drive(input in_t v);
        reset = v.rst; stall = v.stall; br_taken = v.br; imm16 = v.imm;
        jump = v.jump; instr_index = v.idx; jr = v.jr; rs_val = v.rs; halt_req = v.halt;
    endtask

    // ---------------- driver: one clock, then compare against the model ----------------
    task automatic do_cycle(input in_t v);
        logic [31:0] exp_off;
        drive(v);
        model_step(v);
        @(posedge clk);
        #1;
        exp_off = (m_pc - PC_RESET) >> 2;
        check("pc", pc, m_pc);
        check("retired", retired, m_ret);
        check("pc_err", 32'(pc_err), 32'(m_err));
        check("halted", 32'(halted), 32'(m_halt));
        check("fetch_valid", 32'(fetch_valid), 32'(!m_halt && !v.stall));
        check("im_addr", 32'(im_addr), 32'(exp_off[AW-1:0]));
    endtask

    task automatic add_row(input in_t v, input logic [31:0] p, input logic [31:0] r,
                           input bit e, input bit h, input bit fv);
        vec_t row;
        row.in = v; row.exp_pc = p; row.exp_ret = r;
        row.exp_err = e; row.exp_halted = h; row.exp_valid = fv;
        tbl.push_back(row);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] exp_ia;
        in_t v;
        drive(mk(1, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0));
        m_pc = 32'h0; m_ret = 32'h0; m_err = 0; m_halt = 0;
        @(negedge clk);

        // Directed table: inputs and hand-derived outputs after the edge.
        add_row(mk(1, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0),       32'h3000, 0, 0, 0, 1);
        add_row(idle(),                                          32'h3004, 1, 0, 0, 1);
        add_row(idle(),                                          32'h3008, 2, 0, 0, 1);
        add_row(idle(),                                          32'h300C, 3, 0, 0, 1);
        add_row(mk(0, 0, 1, 16'hFFFE, 0, 26'h0, 0, 32'h0, 0),    32'h3008, 4, 0, 0, 1);
        add_row(mk(0, 0, 1, 16'hFFFE, 0, 26'h0, 0, 32'h0, 0),    32'h3004, 5, 0, 0, 1);
        add_row(mk(0, 0, 0, 16'h0, 1, 26'h0C10, 0, 32'h0, 0),    32'h3040, 6, 0, 0, 1);
        add_row(mk(0, 0, 0, 16'h0, 1, 26'h0C10, 1, 32'h3100, 0), 32'h3100, 7, 0, 0, 1);
        for (int i = 0; i < 4; i++)
            add_row(mk(0, 1, 1, 16'h0040, 0, 26'h0, 0, 32'h0, 0), 32'h3100, 7, 0, 0, 0);
        add_row(idle(),                                          32'h3104, 8, 0, 0, 1);
        add_row(mk(0, 0, 1, 16'h0010, 0, 26'h0, 1, 32'h3200, 0), 32'h3200, 9, 0, 0, 1);
        add_row(mk(0, 0, 0, 16'h0, 0, 26'h0, 1, 32'h3102, 0),    32'h3200, 10, 1, 1, 0);
        add_row(mk(0, 0, 0, 16'h0, 1, 26'h0C10, 0, 32'h0, 0),    32'h3200, 10, 1, 1, 0);
        add_row(mk(0, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 1),       32'h3200, 10, 1, 1, 0);
        add_row(mk(0, 1, 1, 16'h0004, 0, 26'h0, 1, 32'h3000, 0), 32'h3200, 10, 1, 1, 0);

        foreach (tbl[i]) begin
            do_cycle(tbl[i].in);
            exp_ia = (tbl[i].exp_pc - PC_RESET) >> 2;
            check($sformatf("tbl%0d_pc", i), pc, tbl[i].exp_pc);
            check($sformatf("tbl%0d_ret", i), retired, tbl[i].exp_ret);
            check($sformatf("tbl%0d_err", i), 32'(pc_err), 32'(tbl[i].exp_err));
            check($sformatf("tbl%0d_halted", i), 32'(halted), 32'(tbl[i].exp_halted));
            check($sformatf("tbl%0d_valid", i), 32'(fetch_valid), 32'(tbl[i].exp_valid));
            check($sformatf("tbl%0d_im", i), 32'(im_addr), 32'(exp_ia[AW-1:0]));
        end

        // Reset out of HALT, advance to 0x3010 and halt there with competing requests.
        do_cycle(mk(1, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0));
        check("rst_from_halt_err", 32'(pc_err), 32'h0);
        for (int i = 0; i < 4; i++) do_cycle(idle());
        check("pc_3010", pc, 32'h3010);
        do_cycle(mk(0, 0, 1, 16'h0008, 1, 26'h0C40, 1, 32'h3400, 1));
        for (int i = 0; i < 5; i++) begin
            do_cycle(mk(0, i[0], 1, 16'h0001, 1, 26'h0C40, 1, 32'h3400, 1));
            check("halt_hold_pc", pc, 32'h3010);
            check("halt_hold_halted", 32'(halted), 32'h1);
        end
        check("halt_no_err", 32'(pc_err), 32'h0);
        check("halt_ret", retired, 32'd5);
        do_cycle(mk(1, 1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 1));
        check("rst_pc", pc, 32'h3000);
        check("rst_halted", 32'(halted), 32'h0);

        // Upper boundary: last word is legal, the next sequential fetch is not.
        do_cycle(mk(0, 0, 0, 16'h0, 0, 26'h0, 1, 32'h6FFC, 0));
        check("last_word_pc", pc, 32'h6FFC);
        check("last_word_im", 32'(im_addr), 32'hFFF);
        do_cycle(idle());
        check("past_end_err", 32'(pc_err), 32'h1);
        check("past_end_pc", pc, 32'h6FFC);

        // Far branch from 0x3FFC lands out of range.
        do_cycle(mk(1, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0));
        do_cycle(mk(0, 0, 0, 16'h0, 0, 26'h0, 1, 32'h3FFC, 0));
        do_cycle(mk(0, 0, 1, 16'h7FFF, 0, 26'h0, 0, 32'h0, 0));
        check("far_br_err", 32'(pc_err), 32'h1);
        check("far_br_pc", pc, 32'h3FFC);

        // Below-base target and negative branch that wraps under the base.
        do_cycle(mk(1, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0));
        do_cycle(mk(0, 0, 1, 16'hFFFE, 0, 26'h0, 0, 32'h0, 0));
        check("below_base_err", 32'(pc_err), 32'h1);
        do_cycle(mk(1, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0));
        do_cycle(mk(0, 0, 0, 16'h0, 0, 26'h0, 1, 32'hFFFF_FFFC, 0));
        check("wrap_target_err", 32'(pc_err), 32'h1);

        // Reset asserted while stalled.
        do_cycle(mk(1, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0));
        do_cycle(idle());
        do_cycle(mk(1, 1, 1, 16'h0004, 0, 26'h0, 0, 32'h0, 0));
        check("rst_in_stall_ret", retired, 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            v = idle();
            v.rst   = m_halt ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 99) == 0);
            v.stall = ($urandom_range(0, 4) == 0);
            v.br    = ($urandom_range(0, 3) == 0);
            v.imm   = 16'($urandom_range(0, 127)) - 16'd64;
            v.jump  = ($urandom_range(0, 9) == 0);
            v.idx   = 26'((PC_RESET >> 2) + $urandom_range(0, IM_DEPTH - 1));
            v.jr    = ($urandom_range(0, 9) == 0);
            v.rs    = ($urandom_range(0, 7) == 0) ? $urandom()
                                                 : PC_RESET + 32'(4 * $urandom_range(0, IM_DEPTH - 1));
            v.halt  = ($urandom_range(0, 49) == 0);
            do_cycle(v);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller for the single-cycle MIPS core. Owns the PC register, computes the next PC from sequential, branch, jump and jump-register requests, and drives the word address into IM. Holds the PC on stall, detects illegal fetch targets, and halts fetch. Sits between the control/ALU outputs of the current instruction and the IM read port.

## Interface
Parameters:
- `PC_RESET`, 32'h0000_3000: PC value after reset; also the IM base address.
- `IM_DEPTH`, 4096: IM size in 32-bit words; must be a power of two.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  reset: **one clock; reset is synchronous and active-high.**
- `stall`  in  1  hold the PC this cycle.
- `br_taken`  in  1  conditional branch resolved taken.
- `imm16`  in  16  branch offset in words, signed.
- `jump`  in  1  j/jal.
- `instr_index`  in  26  jump target field.
- `jr`  in  1  jr.
- `rs_val`  in  32  jr target.
- `halt_req`  in  1  stop fetching.
- `pc`  out  32  current PC, registered.
- `im_addr`  out  log2(IM_DEPTH)  IM word index, equal to (pc − PC_RESET) >> 2.
- `fetch_valid`  out  1  high in RUN while `stall`=0.
- `halted`  out  1  high in HALT.
- `pc_err`  out  1  sticky illegal-target flag.
- `retired`  out  32  count of committed fetches.

## Operation
- FSM states: RUN and HALT.
- Reset: state RUN, `pc`=PC_RESET, `im_addr`=0, `halted`=0, `pc_err`=0, `retired`=0. `fetch_valid`=1 once reset is released.
- In RUN with `stall`=0, npc is the first match in this order:
  1. `jr`: `rs_val`.
  2. `jump`: {pc[31:28], instr_index, 2'b00}.
  3. `br_taken`: pc+4+(sext(imm16)<<2).
  4. Otherwise: pc+4.
- All PC arithmetic is 32-bit modulo 2^32. Any carry out is discarded before the range check.
- npc is legal if npc[1:0]=0 and PC_RESET ≤ npc < PC_RESET+4·IM_DEPTH.
- Legal npc: `pc`←npc and `retired`←`retired`+1 (wraps at 2^32).
- Illegal npc: `pc` holds, `pc_err`←1, state→HALT, `retired`←`retired`+1. The current instruction still commits.
- `halt_req` in RUN with `stall`=0: state→HALT, `pc` holds, `retired`+1, and no redirect is applied. `halt_req` has priority over redirects.
- `stall`=1 in RUN: `pc`, `retired` and state hold. `halt_req` and the redirect inputs are ignored that cycle.
- HALT: all inputs except `reset` are ignored. `pc`, `retired` and `pc_err` freeze. `fetch_valid`=0. HALT is left only through `reset`.

## Timing
- Redirect, stall and halt inputs are sampled at the rising edge. They come from the instruction currently addressed by `pc`.
- `pc`, `im_addr`, state, `pc_err` and `retired` update at that edge, so a redirect takes effect in 1 cycle.
- `fetch_valid` and `halted` are combinational decodes of state and `stall`.
- `im_addr` is derived combinationally from the registered `pc`, so IM output is valid in the same cycle.
- `reset` overrides every other input on the same edge, including mid-stall and in HALT.
- If `jr` and `br_taken` are asserted together, only `jr` applies. This is not an error.

## Structure
- Shared package `mips_pkg`: PC_RESET default, the state encoding enum `fetch_state_t` (RUN, HALT), and the NPC select enum (SEQ, BR, J, JR).
- One sub-module, `npc_calc`: purely combinational target computation plus the legality check.
- `fetch_ctrl` holds the FSM, the PC register and the counter.

## Test plan
- Reset, then 3 cycles with no requests: `pc` goes 0x3000→0x3004→0x3008→0x300C; `im_addr`=3; `retired`=3.
- At pc=0x3008, `br_taken`=1, `imm16`=16'hFFFE: next `pc`=0x3004. Then `jump`=1, `instr_index`=26'h0C10: `pc`=0x3040.
- `jr`=1 and `jump`=1 together, `rs_val`=0x3100: `pc`=0x3100. `jr`=1, `rs_val`=0x3102: `pc` holds, `pc_err`=1, `halted`=1.
- `stall`=1 for 4 cycles with `br_taken`=1: `pc` and `retired` unchanged and `fetch_valid`=0. After `stall` drops, normal sequencing resumes.
- `halt_req`=1 at pc=0x3010: `halted`=1 and `pc`=0x3010 for 5 cycles despite further requests. Asserting `reset` then gives `pc`=0x3000, `halted`=0, `pc_err`=0.
- Branch with `imm16`=16'h7FFF at pc=0x3FFC: target out of range, so HALT is entered and `pc_err`=1.
